// File: rtl/sram_pkg.sv
// Shared constants and types for the parametrised dual-port SRAM model.
// Read-during-write mode encodings and the init sequencer state type.
package sram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        READY
    } init_state_t;

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset fill sequencer: walks the whole array once, writing the fill word
// one address per cycle while holding off external requests.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int INIT_ON_RESET = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_init_busy,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    init_state_t       r_state;
    init_state_t       w_state_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_count_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // IDLE already writes word 0 so the fill takes exactly DEPTH cycles after release.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        o_init_we    = 1'b0;
        o_init_addr  = r_count;
        case (r_state)
            IDLE: begin
                if (!i_rst) begin
                    if (INIT_ON_RESET != 0) begin
                        o_init_we   = 1'b1;
                        o_init_addr = '0;
                        if (DEPTH == 1) begin
                            w_state_next = READY;
                        end else begin
                            w_state_next = INIT;
                            w_count_next = ADDR_W'(1);
                        end
                    end else begin
                        w_state_next = READY;
                    end
                end
            end
            INIT: begin
                o_init_we = 1'b1;
                if (r_count == LAST_ADDR) begin
                    w_state_next = READY;
                end else begin
                    w_count_next = r_count + ADDR_W'(1);
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_init_busy = (INIT_ON_RESET != 0) && (r_state != READY);

endmodule

// File: rtl/sram_dp_param.sv
// True dual-port synchronous SRAM with per-bit write mask, selectable
// read-during-write behaviour, optional output register and post-reset fill.
module sram_dp_param
    import sram_pkg::*;
#(
    parameter int                DATA_W        = 18,
    parameter int                DEPTH         = 1024,
    parameter int                ADDR_W        = $clog2(DEPTH),
    parameter int                OUT_REG       = 0,
    parameter int                RDW_MODE      = RDW_READ_FIRST,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = {DATA_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cen_a,
    input  logic              i_wen_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wmsk_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic              o_rvalid_a,
    input  logic              i_cen_b,
    input  logic              i_wen_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_wmsk_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic              o_rvalid_b,
    output logic              o_init_busy,
    output logic              o_collision
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;

    sram_init_seq #(
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_init_busy (w_init_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr)
    );

    assign o_init_busy = w_init_busy;

    logic w_req_a, w_req_b;
    logic w_wr_a, w_wr_b;
    logic w_rd_a, w_rd_b;
    logic w_inr_a, w_inr_b;
    logic w_same_addr;

    assign w_req_a     = !i_cen_a && !w_init_busy && !i_rst;
    assign w_req_b     = !i_cen_b && !w_init_busy && !i_rst;
    assign w_wr_a      = w_req_a && !i_wen_a;
    assign w_wr_b      = w_req_b && !i_wen_b;
    assign w_rd_a      = w_req_a && i_wen_a;
    assign w_rd_b      = w_req_b && i_wen_b;
    assign w_inr_a     = ({1'b0, i_addr_a} < ADDR_LIMIT);
    assign w_inr_b     = ({1'b0, i_addr_b} < ADDR_LIMIT);
    assign w_same_addr = (i_addr_a == i_addr_b);

    logic [DATA_W-1:0] w_old_a, w_old_b;
    logic [DATA_W-1:0] w_merge_a, w_merge_b;
    logic [DATA_W-1:0] w_dual_merge;
    logic [DATA_W-1:0] w_wword_a, w_wword_b;

    assign w_old_a   = w_inr_a ? r_mem[i_addr_a] : '0;
    assign w_old_b   = w_inr_b ? r_mem[i_addr_b] : '0;
    assign w_merge_a = (w_old_a & i_wmsk_a) | (i_wdata_a & ~i_wmsk_a);
    assign w_merge_b = (w_old_b & i_wmsk_b) | (i_wdata_b & ~i_wmsk_b);

    // Port B's merge is applied first and port A's unmasked bits land on top, so A wins overlaps.
    assign w_dual_merge = (w_merge_b & i_wmsk_a) | (i_wdata_a & ~i_wmsk_a);
    assign w_wword_a    = (w_wr_b && w_same_addr) ? w_dual_merge : w_merge_a;
    assign w_wword_b    = (w_wr_a && w_same_addr) ? w_dual_merge : w_merge_b;

    always_ff @(posedge i_clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= INIT_VALUE;
        end else begin
            if (w_wr_b && w_inr_b) begin
                r_mem[i_addr_b] <= w_wword_b;
            end
            if (w_wr_a && w_inr_a) begin
                r_mem[i_addr_a] <= w_wword_a;
            end
        end
    end

    logic [DATA_W-1:0] w_rd_data_a, w_rd_data_b;

    always_comb begin
        w_rd_data_a = w_old_a;
        w_rd_data_b = w_old_b;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (w_wr_b && w_same_addr && w_inr_a) begin
                w_rd_data_a = w_wword_b;
            end
            if (w_wr_a && w_same_addr && w_inr_b) begin
                w_rd_data_b = w_wword_a;
            end
        end
    end

    logic [DATA_W-1:0] r_rdata1_a, r_rdata1_b;
    logic              r_rvalid1_a, r_rvalid1_b;
    logic              r_collision;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata1_a  <= '0;
            r_rdata1_b  <= '0;
            r_rvalid1_a <= 1'b0;
            r_rvalid1_b <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_rvalid1_a <= w_rd_a;
            r_rvalid1_b <= w_rd_b;
            if (w_rd_a) begin
                r_rdata1_a <= w_rd_data_a;
            end
            if (w_rd_b) begin
                r_rdata1_b <= w_rd_data_b;
            end
            r_collision <= w_req_a && w_req_b && w_same_addr && (w_wr_a || w_wr_b);
        end
    end

    assign o_collision = r_collision;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_rdata2_a, r_rdata2_b;
            logic              r_rvalid2_a, r_rvalid2_b;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_rdata2_a  <= '0;
                    r_rdata2_b  <= '0;
                    r_rvalid2_a <= 1'b0;
                    r_rvalid2_b <= 1'b0;
                end else begin
                    r_rvalid2_a <= r_rvalid1_a;
                    r_rvalid2_b <= r_rvalid1_b;
                    if (r_rvalid1_a) begin
                        r_rdata2_a <= r_rdata1_a;
                    end
                    if (r_rvalid1_b) begin
                        r_rdata2_b <= r_rdata1_b;
                    end
                end
            end

            assign o_rdata_a  = r_rdata2_a;
            assign o_rdata_b  = r_rdata2_b;
            assign o_rvalid_a = r_rvalid2_a;
            assign o_rvalid_b = r_rvalid2_b;
        end else begin : g_no_out_reg
            assign o_rdata_a  = r_rdata1_a;
            assign o_rdata_b  = r_rdata1_b;
            assign o_rvalid_a = r_rvalid1_a;
            assign o_rvalid_b = r_rvalid1_b;
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_param.sv
// Directed bench for sram_dp_param: dut0 is 1024 deep, latency 1, read-first,
// fill 2AAAA; dut1 is 1000 deep, latency 2, write-first, fill 0.
module tb_sram_dp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        cenA   [2];
    logic        wenA   [2];
    logic [9:0]  addrA  [2];
    logic [17:0] wmskA  [2];
    logic [17:0] wdataA [2];
    logic        cenB   [2];
    logic        wenB   [2];
    logic [9:0]  addrB  [2];
    logic [17:0] wmskB  [2];
    logic [17:0] wdataB [2];

    logic [17:0] rdataA0, rdataB0, rdataA1, rdataB1;
    logic        rvalidA0, rvalidB0, rvalidA1, rvalidB1;
    logic        busy0, busy1, col0, col1;

    sram_dp_param #(
        .DATA_W(18), .DEPTH(1024), .OUT_REG(0), .RDW_MODE(0),
        .INIT_ON_RESET(1), .INIT_VALUE(18'h2AAAA)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_cen_a(cenA[0]), .i_wen_a(wenA[0]), .i_addr_a(addrA[0]),
        .i_wmsk_a(wmskA[0]), .i_wdata_a(wdataA[0]),
        .o_rdata_a(rdataA0), .o_rvalid_a(rvalidA0),
        .i_cen_b(cenB[0]), .i_wen_b(wenB[0]), .i_addr_b(addrB[0]),
        .i_wmsk_b(wmskB[0]), .i_wdata_b(wdataB[0]),
        .o_rdata_b(rdataB0), .o_rvalid_b(rvalidB0),
        .o_init_busy(busy0), .o_collision(col0)
    );

    sram_dp_param #(
        .DATA_W(18), .DEPTH(1000), .OUT_REG(1), .RDW_MODE(1),
        .INIT_ON_RESET(1), .INIT_VALUE(18'h00000)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_cen_a(cenA[1]), .i_wen_a(wenA[1]), .i_addr_a(addrA[1]),
        .i_wmsk_a(wmskA[1]), .i_wdata_a(wdataA[1]),
        .o_rdata_a(rdataA1), .o_rvalid_a(rvalidA1),
        .i_cen_b(cenB[1]), .i_wen_b(wenB[1]), .i_addr_b(addrB[1]),
        .i_wmsk_b(wmskB[1]), .i_wdata_b(wdataB[1]),
        .o_rdata_b(rdataB1), .o_rvalid_b(rvalidB1),
        .o_init_busy(busy1), .o_collision(col1)
    );

    typedef struct packed {
        logic [17:0] rdA;
        logic        vA;
        logic [17:0] rdB;
        logic        vB;
        logic        busy;
        logic        col;
    } out_t;

    typedef struct {
        int          dut;
        string       name;
        logic        cenA, wenA;
        logic [9:0]  addrA;
        logic [17:0] wmskA, wdataA;
        logic        cenB, wenB;
        logic [9:0]  addrB;
        logic [17:0] wmskB, wdataB;
        logic        expVA, expVB, expCol;
        logic [17:0] expDA, expDB;
    } vec_t;

    int   nChecks = 0;
    int   nErrors = 0;
    vec_t vecs[$];

    function automatic out_t getOut(input int d);
        out_t o;
        if (d == 0) begin
            o.rdA = rdataA0; o.vA = rvalidA0; o.rdB = rdataB0; o.vB = rvalidB0;
            o.busy = busy0; o.col = col0;
        end else begin
            o.rdA = rdataA1; o.vA = rvalidA1; o.rdB = rdataB1; o.vB = rvalidB1;
            o.busy = busy1; o.col = col1;
        end
        return o;
    endfunction

    // opX: 0 idle, 1 read, 2 write
    function automatic vec_t mkVec(input int dut, input string name,
                                   input int opA, input logic [9:0] aA, input logic [17:0] mA, input logic [17:0] dA,
                                   input int opB, input logic [9:0] aB, input logic [17:0] mB, input logic [17:0] dB,
                                   input logic [17:0] eA, input logic [17:0] eB, input logic eCol);
        vec_t v;
        v.dut = dut; v.name = name;
        v.cenA = (opA == 0); v.wenA = (opA != 2); v.addrA = aA; v.wmskA = mA; v.wdataA = dA;
        v.cenB = (opB == 0); v.wenB = (opB != 2); v.addrB = aB; v.wmskB = mB; v.wdataB = dB;
        v.expVA = (opA == 1); v.expDA = eA;
        v.expVB = (opB == 1); v.expDB = eB;
        v.expCol = eCol;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idlePorts(input int d);
        cenA[d] = 1'b1; wenA[d] = 1'b1; addrA[d] = '0; wmskA[d] = '1; wdataA[d] = '0;
        cenB[d] = 1'b1; wenB[d] = 1'b1; addrB[d] = '0; wmskB[d] = '1; wdataB[d] = '0;
    endtask

    // One request cycle, then two observation cycles covering both read latencies.
    task automatic applyStimulus(input vec_t v);
        int   d;
        int   lat;
        out_t o;
        d   = v.dut;
        lat = (d == 0) ? 1 : 2;
        @(negedge clk);
        cenA[d] = v.cenA; wenA[d] = v.wenA; addrA[d] = v.addrA; wmskA[d] = v.wmskA; wdataA[d] = v.wdataA;
        cenB[d] = v.cenB; wenB[d] = v.wenB; addrB[d] = v.addrB; wmskB[d] = v.wmskB; wdataB[d] = v.wdataB;
        @(negedge clk);
        idlePorts(d);
        o = getOut(d);
        checkOutput({v.name, " collision c1"}, 32'(o.col), 32'(v.expCol));
        checkOutput({v.name, " rvalid_a c1"}, 32'(o.vA), (lat == 1) ? 32'(v.expVA) : 32'd0);
        checkOutput({v.name, " rvalid_b c1"}, 32'(o.vB), (lat == 1) ? 32'(v.expVB) : 32'd0);
        if (lat == 1 && v.expVA) checkOutput({v.name, " rdata_a c1"}, 32'(o.rdA), 32'(v.expDA));
        if (lat == 1 && v.expVB) checkOutput({v.name, " rdata_b c1"}, 32'(o.rdB), 32'(v.expDB));
        @(negedge clk);
        o = getOut(d);
        checkOutput({v.name, " collision c2"}, 32'(o.col), 32'd0);
        checkOutput({v.name, " rvalid_a c2"}, 32'(o.vA), (lat == 2) ? 32'(v.expVA) : 32'd0);
        checkOutput({v.name, " rvalid_b c2"}, 32'(o.vB), (lat == 2) ? 32'(v.expVB) : 32'd0);
        if (v.expVA) checkOutput({v.name, " rdata_a c2"}, 32'(o.rdA), 32'(v.expDA));
        if (v.expVB) checkOutput({v.name, " rdata_b c2"}, 32'(o.rdB), 32'(v.expDB));
    endtask

    task automatic streamTest(input int d);
        int   lat;
        int   k;
        out_t o;
        lat = (d == 0) ? 1 : 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cenA[d] = 1'b0; wenA[d] = 1'b0; addrA[d] = 10'(100 + i); wmskA[d] = '0; wdataA[d] = 18'(18'h01000 + i * 17);
            cenB[d] = 1'b0; wenB[d] = 1'b0; addrB[d] = 10'(200 + i); wmskB[d] = '0; wdataB[d] = 18'(18'h02000 + i * 33);
        end
        @(negedge clk);
        idlePorts(d);
        for (int c = 0; c <= 16 + lat; c++) begin
            @(negedge clk);
            o = getOut(d);
            k = c - lat;
            checkOutput($sformatf("stream dut%0d rvalid_a cycle %0d", d, c), 32'(o.vA), (k >= 0 && k < 16) ? 32'd1 : 32'd0);
            checkOutput($sformatf("stream dut%0d rvalid_b cycle %0d", d, c), 32'(o.vB), (k >= 0 && k < 16) ? 32'd1 : 32'd0);
            if (k >= 0 && k < 16) begin
                checkOutput($sformatf("stream dut%0d rdata_a word %0d", d, k), 32'(o.rdA), 32'(18'h01000 + k * 17));
                checkOutput($sformatf("stream dut%0d rdata_b word %0d", d, k), 32'(o.rdB), 32'(18'h02000 + k * 33));
            end
            if (c < 16) begin
                cenA[d] = 1'b0; wenA[d] = 1'b1; addrA[d] = 10'(100 + c);
                cenB[d] = 1'b0; wenB[d] = 1'b1; addrB[d] = 10'(200 + c);
            end else begin
                idlePorts(d);
            end
        end
    endtask

    initial begin
        int   cnt [2];
        bit   done [2];
        bit   restarted;
        int   stray;
        out_t o;

        cnt[0] = 0; cnt[1] = 0; done[0] = 1'b0; done[1] = 1'b0;
        restarted = 1'b0; stray = 0;

        for (int d = 0; d < 2; d++) begin
            idlePorts(d);
            rst[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = getOut(d);
            checkOutput($sformatf("reset dut%0d rdata_a", d), 32'(o.rdA), 32'd0);
            checkOutput($sformatf("reset dut%0d rdata_b", d), 32'(o.rdB), 32'd0);
            checkOutput($sformatf("reset dut%0d rvalid_a", d), 32'(o.vA), 32'd0);
            checkOutput($sformatf("reset dut%0d rvalid_b", d), 32'(o.vB), 32'd0);
            checkOutput($sformatf("reset dut%0d collision", d), 32'(o.col), 32'd0);
            checkOutput($sformatf("reset dut%0d init_busy", d), 32'(o.busy), 32'd1);
        end

        // Release reset with requests pending on dut0; they must all be dropped.
        rst[0] = 1'b0; rst[1] = 1'b0;
        cenA[0] = 1'b0; wenA[0] = 1'b1; addrA[0] = 10'd0;
        cenB[0] = 1'b0; wenB[0] = 1'b0; addrB[0] = 10'd3; wmskB[0] = '0; wdataB[0] = 18'h3FFFF;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rst[0]) rst[0] = 1'b0;
            if (rvalidA0 || rvalidB0) stray++;
            for (int d = 0; d < 2; d++) begin
                if (!done[d]) begin
                    o = getOut(d);
                    if (o.busy) cnt[d]++;
                    else done[d] = 1'b1;
                end
            end
            if (done[0]) idlePorts(0);
            if (done[0] && done[1]) break;
            if (!restarted && cnt[0] == 500) begin
                rst[0] = 1'b1;
                cnt[0] = 0;
                restarted = 1'b1;
            end
        end
        checkOutput("init finished within budget", 32'(done[0] && done[1]), 32'd1);
        checkOutput("dut0 init_busy cycles after restart", 32'(cnt[0]), 32'd1024);
        checkOutput("dut1 init_busy cycles", 32'(cnt[1]), 32'd1000);
        checkOutput("rvalid during init", 32'(stray), 32'd0);

        vecs.push_back(mkVec(0, "d0 read 0/1023", 1, 10'd0, '1, '0, 1, 10'd1023, '1, '0, 18'h2AAAA, 18'h2AAAA, 1'b0));
        vecs.push_back(mkVec(0, "d0 read 3 init-dropped write", 1, 10'd3, '1, '0, 0, 10'd0, '1, '0, 18'h2AAAA, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 clear 5", 2, 10'd5, 18'h00000, 18'h00000, 0, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 masked write 5", 2, 10'd5, 18'h0FF00, 18'h3FFFF, 0, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 read 5", 0, 10'd0, '1, '0, 1, 10'd5, '1, '0, 18'h0, 18'h300FF, 1'b0));
        vecs.push_back(mkVec(0, "d0 dual write 7", 2, 10'd7, 18'h0, 18'h00001, 2, 10'd7, 18'h0, 18'h00002, 18'h0, 18'h0, 1'b1));
        vecs.push_back(mkVec(0, "d0 read 7", 1, 10'd7, '1, '0, 0, 10'd0, '1, '0, 18'h00001, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 write 9", 2, 10'd9, 18'h0, 18'h00011, 0, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 A wr B rd 9", 2, 10'd9, 18'h0, 18'h00022, 1, 10'd9, '1, '0, 18'h0, 18'h00011, 1'b1));
        vecs.push_back(mkVec(0, "d0 both read 9", 1, 10'd9, '1, '0, 1, 10'd9, '1, '0, 18'h00022, 18'h00022, 1'b0));
        vecs.push_back(mkVec(0, "d0 dual union 12", 2, 10'd12, 18'h3FF00, 18'h000FF, 2, 10'd12, 18'h000FF, 18'h3FF00, 18'h0, 18'h0, 1'b1));
        vecs.push_back(mkVec(0, "d0 read 12", 0, 10'd0, '1, '0, 1, 10'd12, '1, '0, 18'h0, 18'h3FFFF, 1'b0));
        vecs.push_back(mkVec(0, "d0 dual overlap 13", 2, 10'd13, 18'h3FFF0, 18'h00005, 2, 10'd13, 18'h3FF00, 18'h000AA, 18'h0, 18'h0, 1'b1));
        vecs.push_back(mkVec(0, "d0 read 13", 1, 10'd13, '1, '0, 0, 10'd0, '1, '0, 18'h2AAA5, 18'h0, 1'b0));
        vecs.push_back(mkVec(0, "d0 B wr A rd 9", 1, 10'd9, '1, '0, 2, 10'd9, 18'h0, 18'h00033, 18'h00022, 18'h0, 1'b1));
        vecs.push_back(mkVec(0, "d0 read 9 after B wr", 0, 10'd0, '1, '0, 1, 10'd9, '1, '0, 18'h0, 18'h00033, 1'b0));
        vecs.push_back(mkVec(1, "d1 read 0/999", 1, 10'd0, '1, '0, 1, 10'd999, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(1, "d1 masked write 5", 2, 10'd5, 18'h0FF00, 18'h3FFFF, 0, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(1, "d1 read 5", 0, 10'd0, '1, '0, 1, 10'd5, '1, '0, 18'h0, 18'h300FF, 1'b0));
        vecs.push_back(mkVec(1, "d1 write 9", 2, 10'd9, 18'h0, 18'h00011, 0, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(1, "d1 A wr B rd 9", 2, 10'd9, 18'h0, 18'h00022, 1, 10'd9, '1, '0, 18'h0, 18'h00022, 1'b1));
        vecs.push_back(mkVec(1, "d1 B masked wr A rd 9", 1, 10'd9, '1, '0, 2, 10'd9, 18'h3FF0F, 18'h00033, 18'h00032, 18'h0, 1'b1));
        vecs.push_back(mkVec(1, "d1 read 9", 0, 10'd0, '1, '0, 1, 10'd9, '1, '0, 18'h0, 18'h00032, 1'b0));
        vecs.push_back(mkVec(1, "d1 write 1010", 0, 10'd0, '1, '0, 2, 10'd1010, 18'h0, 18'h3FFFF, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(1, "d1 read 1010/10", 1, 10'd1010, '1, '0, 1, 10'd10, '1, '0, 18'h0, 18'h0, 1'b0));
        vecs.push_back(mkVec(1, "d1 read 999/0", 1, 10'd999, '1, '0, 1, 10'd0, '1, '0, 18'h0, 18'h0, 1'b0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        streamTest(0);
        streamTest(1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
